// File: rtl/counter_seq_if.sv
// Host-side control and status bundle for the counter sequencer.
// The host (master) writes the reload table, configures and starts/stops
// a sequence, and watches the progress flags; the sequencer is the slave.
interface counter_seq_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic [AW:0]      cfg_len;
    logic             cfg_loop;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;
    logic             event_pulse;
    logic             err;
    logic [AW-1:0]    seq_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_len, cfg_loop, start, stop,
        input  busy, done, event_pulse, err, seq_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_len, cfg_loop, start, stop,
        output busy, done, event_pulse, err, seq_idx
    );
endinterface

// File: rtl/counter_seq.sv
// Sequencer for the shared down-counter: loads a programmable table of
// reload values one entry at a time, advancing on each terminal-count edge,
// optionally looping, and reporting progress to the host. It is the sole
// driver of the counter's bidirectional value bus.
module counter_seq #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    counter_seq_if.slave      host,
    inout  wire  [WIDTH-1:0]  cnt_bus,
    output logic [1:0]        cnt_setup,
    output logic              cnt_restart,
    input  logic              cnt_match
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SKIP,
        S_WAIT
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    state_t           state_q, state_n;
    logic [AW-1:0]    idx_q, idx_n;
    logic [AW:0]      len_q, len_n;
    logic             loop_q, loop_n;
    logic             pass_any_q, pass_any_n;
    logic             err_q, err_n;
    logic             done_q, done_n;
    logic             event_q, event_n;
    logic             restart_q, restart_n;
    logic             match_d;
    logic             match_rise;
    logic             advance;
    logic             is_last;
    logic [AW-1:0]    adv_idx;
    logic [WIDTH-1:0] entry_q [DEPTH];

    assign match_rise = cnt_match & ~match_d;

    // Next-state and pulse logic; stop overrides everything, and a pass
    // that ends without a single load while looping is flagged as an error.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        len_n      = len_q;
        loop_n     = loop_q;
        pass_any_n = pass_any_q;
        err_n      = err_q;
        done_n     = 1'b0;
        event_n    = 1'b0;
        restart_n  = 1'b0;
        advance    = 1'b0;
        adv_idx    = idx_q + 1'b1;
        is_last    = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

        if (host.stop) begin
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host.start) begin
                        idx_n      = '0;
                        loop_n     = host.cfg_loop;
                        err_n      = 1'b0;
                        pass_any_n = 1'b0;
                        if (host.cfg_len == '0 || host.cfg_len > LEN_MAX)
                            len_n = LEN_MAX;
                        else
                            len_n = host.cfg_len;
                        state_n = (entry_q[0] == '0) ? S_SKIP : S_LOAD;
                    end
                end
                S_LOAD: state_n = S_WAIT;
                S_SKIP: advance = 1'b1;
                S_WAIT: begin
                    if (host.start) begin
                        restart_n = 1'b1;
                    end else if (match_rise) begin
                        event_n = 1'b1;
                        advance = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase

            if (advance) begin
                if (!is_last) begin
                    idx_n   = adv_idx;
                    state_n = (entry_q[adv_idx] == '0) ? S_SKIP : S_LOAD;
                end else if (loop_q && pass_any_q) begin
                    idx_n      = '0;
                    pass_any_n = 1'b0;
                    state_n    = (entry_q[0] == '0) ? S_SKIP : S_LOAD;
                end else begin
                    err_n   = err_q | loop_q;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
        end

        if (state_n == S_LOAD)
            pass_any_n = 1'b1;
    end

    // Sequencer state, configuration latches and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= LEN_MAX;
            loop_q     <= 1'b0;
            pass_any_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            event_q    <= 1'b0;
            restart_q  <= 1'b0;
            match_d    <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            len_q      <= len_n;
            loop_q     <= loop_n;
            pass_any_q <= pass_any_n;
            err_q      <= err_n;
            done_q     <= done_n;
            event_q    <= event_n;
            restart_q  <= restart_n;
            match_d    <= cnt_match;
        end
    end

    // Reload table; host writes land immediately and are seen at the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                entry_q[i] <= '0;
        end else if (host.cfg_we) begin
            entry_q[host.cfg_addr] <= host.cfg_data;
        end
    end

    assign host.busy        = (state_q != S_IDLE);
    assign host.done        = done_q;
    assign host.event_pulse = event_q;
    assign host.err         = err_q;
    assign host.seq_idx     = idx_q;
    assign cnt_setup        = (state_q == S_LOAD) ? 2'b11 : 2'b00;
    assign cnt_restart      = restart_q;
    assign cnt_bus          = (state_q == S_LOAD) ? entry_q[idx_q] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_counter_seq.sv
// Directed testbench for counter_seq: a vector table for the basic
// one-shot pass plus hand-written sequences for looping, skipping,
// error, retrigger, held match, live table writes and async reset.
module tb_counter_seq;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct {
        logic             start;
        logic             stop;
        logic             match;
        logic             busy;
        logic             done;
        logic             ev;
        logic [1:0]       setup;
        logic [AW-1:0]    idx;
        logic [WIDTH-1:0] bus;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_match;
    wire  [WIDTH-1:0] cnt_bus;
    logic [1:0]       cnt_setup;
    logic             cnt_restart;
    int               n_checks = 0;
    int               n_fails = 0;
    int               ev_count;
    vec_t             vecs [10];
    logic [WIDTH-1:0] tbl [4];

    counter_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) host_if ();

    counter_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host_if),
        .cnt_bus     (cnt_bus),
        .cnt_setup   (cnt_setup),
        .cnt_restart (cnt_restart),
        .cnt_match   (cnt_match)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic m);
        host_if.start = s;
        host_if.stop  = p;
        cnt_match     = m;
        step();
    endtask

    task automatic writeTable(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        host_if.cfg_we   = 1'b1;
        host_if.cfg_addr = a;
        host_if.cfg_data = d;
        step();
        host_if.cfg_we   = 1'b0;
    endtask

    task automatic cmp(input string what, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic e_busy, input logic e_done,
                               input logic e_ev, input logic [1:0] e_setup,
                               input logic [AW-1:0] e_idx, input logic [WIDTH-1:0] e_bus,
                               input logic e_restart, input logic e_err);
        cmp({name, ".busy"},    16'(host_if.busy),        16'(e_busy));
        cmp({name, ".done"},    16'(host_if.done),        16'(e_done));
        cmp({name, ".event"},   16'(host_if.event_pulse), 16'(e_ev));
        cmp({name, ".setup"},   16'(cnt_setup),           16'(e_setup));
        cmp({name, ".idx"},     16'(host_if.seq_idx),     16'(e_idx));
        cmp({name, ".restart"}, 16'(cnt_restart),         16'(e_restart));
        cmp({name, ".err"},     16'(host_if.err),         16'(e_err));
        if (e_setup == 2'b11)
            cmp({name, ".bus"}, cnt_bus, e_bus);
    endtask

    task automatic loadTable(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        writeTable(2'd0, a);
        writeTable(2'd1, b);
        writeTable(2'd2, c);
        writeTable(2'd3, d);
    endtask

    // Main stimulus sequence.
    initial begin
        tbl[0] = 16'd9;
        tbl[1] = 16'd15;
        tbl[2] = 16'd7;
        tbl[3] = 16'd10;
        //           start stop  match busy  done  ev    setup  idx   bus
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'd0, 16'd9};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'd1, 16'd15};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd1, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'd2, 16'd7};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd2, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'd3, 16'd10};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd3, 16'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'd3, 16'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 16'd0};

        host_if.cfg_we   = 1'b0;
        host_if.cfg_addr = '0;
        host_if.cfg_data = '0;
        host_if.cfg_len  = 3'd4;
        host_if.cfg_loop = 1'b0;
        host_if.start    = 1'b0;
        host_if.stop     = 1'b0;
        cnt_match        = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);

        // One-shot pass over {9,15,7,10}.
        loadTable(tbl[0], tbl[1], tbl[2], tbl[3]);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].match);
            checkOutput($sformatf("oneshot%0d", i), vecs[i].busy, vecs[i].done, vecs[i].ev,
                        vecs[i].setup, vecs[i].idx, vecs[i].bus, 1'b0, 1'b0);
        end

        // Loop mode: a match edge during LOAD is discarded, then ten matches wrap the index.
        host_if.cfg_loop = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("loop_start", 1'b1, 1'b0, 1'b0, 2'b11, 2'd0, 16'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("loop_discard", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("loop_held", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("loop_m%0d", k), 1'b1, 1'b0, 1'b1, 2'b11,
                        2'((k + 1) % 4), tbl[(k + 1) % 4], 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("loop_stop", 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("loop_stop_after", 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 16'd0, 1'b0, 1'b0);

        // Zero entries are skipped in one cycle each without an event.
        host_if.cfg_loop = 1'b0;
        loadTable(16'd5, 16'd0, 16'd0, 16'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("skip_load0", 1'b1, 1'b0, 1'b0, 2'b11, 2'd0, 16'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("skip_idx1", 1'b1, 1'b0, 1'b1, 2'b00, 2'd1, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("skip_idx2", 1'b1, 1'b0, 1'b0, 2'b00, 2'd2, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("skip_load3", 1'b1, 1'b0, 1'b0, 2'b11, 2'd3, 16'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("skip_done", 1'b0, 1'b1, 1'b1, 2'b00, 2'd3, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // All-zero table in loop mode flags an error after one pass.
        loadTable(16'd0, 16'd0, 16'd0, 16'd0);
        host_if.cfg_loop = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("zero_skip0", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("zero_skip3", 1'b1, 1'b0, 1'b0, 2'b00, 2'd3, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("zero_err", 1'b0, 1'b1, 1'b0, 2'b00, 2'd3, 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("zero_sticky", 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 16'd0, 1'b0, 1'b1);

        // Restart clears err; a length of zero is treated as the full table.
        host_if.cfg_loop = 1'b0;
        host_if.cfg_len  = 3'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("clr_err", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("len0_last", 1'b1, 1'b0, 1'b0, 2'b00, 2'd3, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("len0_done", 1'b0, 1'b1, 1'b0, 2'b00, 2'd3, 16'd0, 1'b0, 1'b0);

        // Retrigger in WAIT, start ignored in LOAD, and a long held match.
        host_if.cfg_len = 3'd4;
        loadTable(tbl[0], tbl[1], tbl[2], tbl[3]);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("retrig", 1'b1, 1'b0, 1'b0, 2'b00, 2'd1, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("retrig_end", 1'b1, 1'b0, 1'b0, 2'b00, 2'd1, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("retrig_load2", 1'b1, 1'b0, 1'b1, 2'b11, 2'd2, 16'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_in_load", 1'b1, 1'b0, 1'b0, 2'b00, 2'd2, 16'd0, 1'b0, 1'b0);
        ev_count = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (host_if.event_pulse)
                ev_count++;
        end
        cmp("held_match.events", 16'(ev_count), 16'd1);
        checkOutput("held_match", 1'b1, 1'b0, 1'b0, 2'b00, 2'd3, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("held_stop", 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 16'd0, 1'b0, 1'b0);

        // Live write to entry 1 is picked up on its next load, then async reset mid-WAIT.
        host_if.cfg_loop = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("live_load1", 1'b1, 1'b0, 1'b1, 2'b11, 2'd1, 16'd15, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        writeTable(2'd1, 16'd42);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("live_reload1", 1'b1, 1'b0, 1'b1, 2'b11, 2'd1, 16'd42, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        host_if.cfg_loop = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("table_cleared", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("final_stop", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/counter_seq.md
# counter_seq

Sequencer that drives the shared down-counter's load bus and control lines, stepping it through a programmable table of reload values. On each terminal-count match it advances to the next entry, optionally looping, and reports progress to the host. It sits between the host control logic and the counter instance. It is the only driver of the counter's bidirectional value bus.

## Interface
- WIDTH, 16, counter and table entry width
- DEPTH, 4, number of table entries (power of two, ≥2)
- AW, $clog2(DEPTH), table address / index width

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write address
- cfg_data  in  WIDTH  table write data
- cfg_len  in  AW+1  entries per pass (1..DEPTH), sampled at start
- cfg_loop  in  1  1 = repeat table forever, sampled at start
- start  in  1  one-cycle start/retrigger request
- stop  in  1  one-cycle abort request
- busy  out  1  sequence active
- done  out  1  one-cycle pulse on normal completion
- event_pulse  out  1  one-cycle pulse per consumed match
- err  out  1  sticky: loop pass with every entry zero; cleared by start
- seq_idx  out  AW  index of entry currently counting
- cnt_bus  inout  WIDTH  counter value bus; driven only while cnt_setup==2'b11, else high-Z
- cnt_setup  out  2  2'b00 idle/run, 2'b11 full-width load
- cnt_restart  out  1  one-cycle restart pulse to the counter
- cnt_match  in  1  counter terminal-count flag

## Operation
- Counter contract: in the cycle where cnt_setup==2'b11, the counter loads cnt_bus. The counter then counts down and raises cnt_match at zero. A cnt_restart pulse reloads the counter from the last loaded value.
- The table is a DEPTH×WIDTH register array. Writes are accepted at any time. A write during a sequence takes effect the next time that entry is loaded.
- A match is the rising edge of cnt_match, detected with a registered copy (match_d). Only the edge counts; a held-high level is not re-counted.
- States:
  - IDLE: start → LOAD with idx=0; latch cfg_len and cfg_loop; clear err.
  - LOAD: exactly one cycle. Drive table[idx] on cnt_bus with cnt_setup=2'b11. Next state is WAIT.
  - SKIP: one cycle, used when table[idx]==0. No load and no event_pulse. Advance exactly as on a match.
  - WAIT: cnt_setup=2'b00, bus released. On a match: event_pulse=1, then advance.
- Advance rule:
  - If idx<len-1: idx+1 → LOAD (or SKIP if that entry is zero).
  - Else, if loop=1: idx=0 → LOAD/SKIP.
  - Else: done=1 → IDLE.
- Loop mode with a complete pass in which every entry was skipped: set err, pulse done, go to IDLE.
- start while busy (retrigger): pulse cnt_restart for one cycle and stay in WAIT with idx unchanged. A start in LOAD or SKIP is ignored.
- stop in any state: go to IDLE next cycle; cnt_setup=00, bus high-Z, no done. stop wins over a simultaneous start or match.
- A match arriving in the same cycle as LOAD is discarded, because the counter is being reloaded.
- cfg_len of 0 or greater than DEPTH is clamped to DEPTH.

## Timing
- Reset (async assert, sync deassert by system):
  - Control outputs: busy=0, done=0, event_pulse=0, err=0, seq_idx=0, cnt_setup=2'b00, cnt_restart=0.
  - cnt_bus is high-Z.
  - All table entries are 0, and match_d=0.
- start sampled at edge T: busy=1 and LOAD (cnt_setup=11, bus driven) during cycle T+1. WAIT begins at T+2.
- Match edge detected at edge M: event_pulse and the next LOAD both occur in cycle M+1. Zero extra dead cycles.
- Completion: done and busy=0 occur in cycle M+1. done lasts exactly one cycle.
- Retrigger: cnt_restart is high in the cycle after start is sampled.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-sequence: outputs go to reset values immediately, and cnt_bus is released asynchronously.

## Test plan
- Reset, then write table={9,15,7,10}, cfg_len=4, cfg_loop=0, start → four LOADs with cnt_bus=9,15,7,10 and seq_idx=0..3. Expect 4 event_pulses, then done one cycle after the 4th match, and busy=0.
- Same table with cfg_loop=1, run 10 matches → seq_idx wraps 3→0 and busy stays 1. Then stop → IDLE next cycle, setup=00, bus high-Z, no done.
- Table={5,0,0,3}, len=4 → entries 1 and 2 are skipped in one cycle each with no event. Only 2 event_pulses, then done.
- All-zero table with loop=1 → err=1 and done pulse after one pass. A following start clears err.
- Retrigger: start during WAIT → cnt_restart pulses once and idx is unchanged. A match held high for 20 cycles yields exactly one event_pulse.
- Table write to the active entry mid-count, then assert rst_n=0 mid-WAIT → the new value is used at the next load of that entry. During reset, all outputs return to reset values and cnt_bus is high-Z.
